// File: rtl/cfi_trace_lane_packer_if.sv
// Event stream into the lane packer and the packed 4-lane word out of it.
// master = event source / word consumer, slave = packer.
interface cfi_trace_lane_packer_if;
    logic         ev_valid;
    logic         ev_ready;
    logic [3:0]   ev_hdr;
    logic [31:0]  ev_data;
    logic         ev_state;
    logic [31:0]  ev_cid;
    logic [4:0]   des;
    logic [15:0]  deh;
    logic [127:0] ded;
    logic [31:0]  dec;

    modport master (
        output ev_valid, ev_hdr, ev_data, ev_state, ev_cid,
        input  ev_ready, des, deh, ded, dec
    );

    modport slave (
        input  ev_valid, ev_hdr, ev_data, ev_state, ev_cid,
        output ev_ready, des, deh, ded, dec
    );
endinterface

// File: rtl/cfi_trace_lane_packer.sv
// Packs decoded trace events (atom runs compressed) into 4-lane CFI words; optional counters under CFI_PACK_STATS_EN.
// Latency: word strobes one cycle after the edge that completes it.
// Backpressure: ev_ready drops for one cycle only to flush pending lanes on a context-ID change.
module cfi_trace_lane_packer #(
    parameter int TIMEOUT   = 64,
    parameter int MAX_ATOMS = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    cfi_trace_lane_packer_if.slave bus
`ifdef CFI_PACK_STATS_EN
    ,
    output logic [31:0]            stat_words,
    output logic [15:0]            stat_cid_flush,
    output logic [15:0]            stat_timeouts
`endif
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_FILL,
        S_ATOM_OPEN,
        S_EMIT,
        S_CID_FLUSH
    } state_e;

    typedef struct packed {
        logic [3:0]  hdr;
        logic        st;
        logic [31:0] dat;
    } lane_t;

    localparam logic [3:0] HDR_NULL = 4'd0;
    localparam logic [3:0] HDR_ATOM = 4'd1;
    localparam logic [7:0] TMO      = 8'(TIMEOUT);
    localparam logic [4:0] MAXA     = 5'(MAX_ATOMS);

    state_e          state_q, state_d;
    lane_t [3:0]     lanes_q, lanes_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            atom_open_q, atom_open_d;
    logic [4:0]      atom_n_q, atom_n_d;
    logic [7:0]      tmo_q, tmo_d;
    logic [31:0]     cid_q, cid_d;
    logic [4:0]      des_q, des_d;
    logic [15:0]     deh_q, deh_d;
    logic [127:0]    ded_q, ded_d;
    logic [31:0]     dec_q, dec_d;

    logic            emit_now;
    logic            pending;
    logic            ev_null;
    logic            cid_stall;
    logic            ev_acc;
    logic            is_ctrl;
    logic            tmo_hit;
    logic            trig;
    logic [1:0]      lane_idx;
    logic [4:0]      atom_sh;

    always_comb begin
        // An emission cycle hands the held lanes to the output, so new events build on empty lanes.
        emit_now    = (state_q == S_EMIT) || (state_q == S_CID_FLUSH);
        lanes_d     = emit_now ? '0 : lanes_q;
        cnt_d       = emit_now ? 3'd0 : cnt_q;
        atom_open_d = emit_now ? 1'b0 : atom_open_q;
        atom_n_d    = emit_now ? 5'd0 : atom_n_q;
        cid_d       = cid_q;
        pending     = (cnt_d != 3'd0);
        ev_null     = (bus.ev_hdr == HDR_NULL);
        cid_stall   = bus.ev_valid && !ev_null && pending && (bus.ev_cid != cid_q);
        ev_acc      = bus.ev_valid && !cid_stall && !ev_null;
        is_ctrl     = ev_acc && (bus.ev_hdr >= 4'd3) && (bus.ev_hdr <= 4'd6);
        lane_idx    = cnt_d[1:0];
        atom_sh     = 5'd0;

        if (ev_acc) begin
            cid_d = bus.ev_cid;
            if ((bus.ev_hdr == HDR_ATOM) && atom_open_d) begin
                // Move the end-of-run marker from odd bit 2n-1 to 2n+1.
                lane_idx = cnt_d[1:0] - 2'd1;
                atom_sh  = {atom_n_d[3:0], 1'b0};
                lanes_d[lane_idx].dat = (lanes_d[lane_idx].dat & ~(32'd1 << (atom_sh - 5'd1)))
                                      | ({31'd0, bus.ev_data[0]} << atom_sh)
                                      | (32'd1 << (atom_sh + 5'd1));
                atom_n_d    = atom_n_d + 5'd1;
                atom_open_d = (atom_n_d != MAXA);
            end else if (bus.ev_hdr == HDR_ATOM) begin
                lanes_d[lane_idx] = '{hdr: HDR_ATOM, st: bus.ev_state,
                                      dat: {30'd0, 1'b1, bus.ev_data[0]}};
                cnt_d       = cnt_d + 3'd1;
                atom_n_d    = 5'd1;
                atom_open_d = (MAXA != 5'd1);
            end else begin
                lanes_d[lane_idx] = '{hdr: bus.ev_hdr, st: bus.ev_state, dat: bus.ev_data};
                cnt_d       = cnt_d + 3'd1;
                atom_n_d    = 5'd0;
                atom_open_d = 1'b0;
            end
        end

        if (emit_now || ev_acc) begin
            tmo_d = 8'd0;
        end else if (pending) begin
            tmo_d = (tmo_q >= TMO) ? TMO : tmo_q + 8'd1;
        end else begin
            tmo_d = 8'd0;
        end
        tmo_hit = (tmo_d == TMO);

        trig = (cnt_d != 3'd0) &&
               ((cnt_d == 3'd4) || is_ctrl || flush || tmo_hit);

        // A stalled context change already forces the emission, so it wins over other triggers.
        if (cid_stall) begin
            state_d = S_CID_FLUSH;
        end else if (trig) begin
            state_d = S_EMIT;
        end else if (cnt_d == 3'd0) begin
            state_d = S_EMPTY;
        end else if (atom_open_d) begin
            state_d = S_ATOM_OPEN;
        end else begin
            state_d = S_FILL;
        end

        des_d = {1'b0, des_q[3:0]};
        deh_d = deh_q;
        ded_d = ded_q;
        dec_d = dec_q;
        if (emit_now) begin
            des_d[4] = 1'b1;
            dec_d    = cid_q;
            for (int k = 0; k < 4; k++) begin
                des_d[k]          = lanes_q[k].st;
                deh_d[4*k +: 4]   = lanes_q[k].hdr;
                ded_d[32*k +: 32] = lanes_q[k].dat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            lanes_q     <= '0;
            cnt_q       <= 3'd0;
            atom_open_q <= 1'b0;
            atom_n_q    <= 5'd0;
            tmo_q       <= 8'd0;
            cid_q       <= 32'd0;
            des_q       <= 5'd0;
            deh_q       <= 16'd0;
            ded_q       <= 128'd0;
            dec_q       <= 32'd0;
        end else begin
            state_q     <= state_d;
            lanes_q     <= lanes_d;
            cnt_q       <= cnt_d;
            atom_open_q <= atom_open_d;
            atom_n_q    <= atom_n_d;
            tmo_q       <= tmo_d;
            cid_q       <= cid_d;
            des_q       <= des_d;
            deh_q       <= deh_d;
            ded_q       <= ded_d;
            dec_q       <= dec_d;
        end
    end

    assign bus.ev_ready = !cid_stall;
    assign bus.des      = des_q;
    assign bus.deh      = deh_q;
    assign bus.ded      = ded_q;
    assign bus.dec      = dec_q;

`ifdef CFI_PACK_STATS_EN
    logic [31:0] st_words_q, st_words_d;
    logic [15:0] st_cid_q, st_cid_d;
    logic [15:0] st_tmo_q, st_tmo_d;

    always_comb begin
        st_words_d = st_words_q;
        st_cid_d   = st_cid_q;
        st_tmo_d   = st_tmo_q;
        if (emit_now && (st_words_q != '1)) begin
            st_words_d = st_words_q + 32'd1;
        end
        if ((state_q == S_CID_FLUSH) && (st_cid_q != '1)) begin
            st_cid_d = st_cid_q + 16'd1;
        end
        if ((state_d == S_EMIT) && tmo_hit && (st_tmo_q != '1)) begin
            st_tmo_d = st_tmo_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_words_q <= 32'd0;
            st_cid_q   <= 16'd0;
            st_tmo_q   <= 16'd0;
        end else begin
            st_words_q <= st_words_d;
            st_cid_q   <= st_cid_d;
            st_tmo_q   <= st_tmo_d;
        end
    end

    assign stat_words     = st_words_q;
    assign stat_cid_flush = st_cid_q;
    assign stat_timeouts  = st_tmo_q;
`endif

endmodule
